// File: rtl/common_pkg.sv
// Shared definitions for the writeback path: register-file geometry and
// the long-latency result buffer entry format.
package common;
  localparam int REGISTER_FILE_SIZE = 32;
  localparam int FIFO_DEPTH_WB      = 4;

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_arbiter_fifo.sv
// In-order buffer of long-latency writeback entries; DEPTH must be a power of two.
module wb_fifo
  import common::*;
#(
  parameter int DEPTH = FIFO_DEPTH_WB
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  wb_entry_t              push_data,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wb_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_push, w_pop;

  // Pop on empty is ignored, so a push into an empty buffer simply lands.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write port arbiter: ALU results vs buffered long-latency
// results, with starvation relief and a pending-destination scoreboard.
module writeback_arbiter
  import common::*;
#(
  parameter int FIFO_DEPTH   = FIFO_DEPTH_WB,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          alu_valid,
  input  logic [4:0]                    alu_id,
  input  logic [31:0]                   alu_data,
  output logic                          alu_stall,
  input  logic                          lat_valid,
  output logic                          lat_ready,
  input  logic [4:0]                    lat_id,
  input  logic [31:0]                   lat_data,
  input  logic                          reserve_en,
  input  logic [4:0]                    reserve_id,
  output logic                          rf_write_en,
  output logic [4:0]                    rf_write_id,
  output logic [31:0]                   rf_write_data,
  output logic [REGISTER_FILE_SIZE-1:0] pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0]                 r_starve;
  logic [REGISTER_FILE_SIZE-1:0] r_pending, w_pending_nxt;
  logic                          r_wr_en;
  logic [4:0]                    r_wr_id;
  logic [31:0]                   r_wr_data;

  wb_entry_t                     w_head, w_push_entry;
  logic                          w_fifo_full, w_fifo_empty;
  logic                          w_push, w_pop, w_alu_sel;

  assign lat_ready    = reset_n && !w_fifo_full;
  // id 0 is accepted by the handshake but never enters the buffer.
  assign w_push       = lat_valid && lat_ready && (lat_id != 5'd0);
  assign w_push_entry = '{id: lat_id, data: lat_data};

  assign alu_stall = (r_starve == STARVE_MAX) && !w_fifo_empty;
  assign w_alu_sel = !alu_stall && alu_valid && (alu_id != 5'd0);
  assign w_pop     = !w_alu_sel && !w_fifo_empty;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .head      (w_head),
    .count     (fifo_count),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n)                   r_starve <= '0;
    else if (w_pop || w_fifo_empty) r_starve <= '0;
    else if (w_alu_sel && r_starve != STARVE_MAX)
      r_starve <= r_starve + 1'b1;
  end

  // A fresh reservation overrides the clear from a committing older op.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop) w_pending_nxt[w_head.id] = 1'b0;
    if (reserve_en && reserve_id != 5'd0) w_pending_nxt[reserve_id] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_pending <= '0;
    else          r_pending <= w_pending_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_en   <= 1'b0;
      r_wr_id   <= '0;
      r_wr_data <= '0;
    end else if (w_alu_sel) begin
      r_wr_en   <= 1'b1;
      r_wr_id   <= alu_id;
      r_wr_data <= alu_data;
    end else if (w_pop) begin
      r_wr_en   <= 1'b1;
      r_wr_id   <= w_head.id;
      r_wr_data <= w_head.data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign rf_write_en   = r_wr_en;
  assign rf_write_id   = r_wr_id;
  assign rf_write_data = r_wr_data;
  assign pending       = r_pending;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter (FIFO_DEPTH=4, STARVE_LIMIT=3).
module tb_writeback_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid, lat_valid, reserve_en;
  logic [4:0]  alu_id, lat_id, reserve_id;
  logic [31:0] alu_data, lat_data;
  logic        alu_stall, lat_ready, rf_write_en;
  logic [4:0]  rf_write_id;
  logic [31:0] rf_write_data, pending;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  writeback_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_id(alu_id), .alu_data(alu_data), .alu_stall(alu_stall),
    .lat_valid(lat_valid), .lat_ready(lat_ready), .lat_id(lat_id), .lat_data(lat_data),
    .reserve_en(reserve_en), .reserve_id(reserve_id),
    .rf_write_en(rf_write_en), .rf_write_id(rf_write_id), .rf_write_data(rf_write_data),
    .pending(pending), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_id = 0; alu_data = 0;
    lat_valid = 0; lat_id = 0; lat_data = 0;
    reserve_en = 0; reserve_id = 0;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [4:0] id, input logic [31:0] data);
    chk({tag, "_en"}, 32'(rf_write_en), 32'(en));
    if (en) begin
      chk({tag, "_id"}, 32'(rf_write_id), 32'(id));
      chk({tag, "_data"}, rf_write_data, data);
    end
  endtask

  initial begin
    // Reset held with every input active
    reset_n = 0;
    alu_valid = 1; alu_id = 5; alu_data = 32'hFFFF_0000;
    lat_valid = 1; lat_id = 3; lat_data = 32'h33;
    reserve_en = 1; reserve_id = 9;
    tick(); tick();
    chk("rst_en", 32'(rf_write_en), 0);
    chk("rst_id", 32'(rf_write_id), 0);
    chk("rst_data", rf_write_data, 0);
    chk("rst_pending", pending, 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_lat_ready", 32'(lat_ready), 0);
    chk("rst_stall", 32'(alu_stall), 0);
    idle();
    reset_n = 1;
    #1;
    chk("rel_lat_ready", 32'(lat_ready), 1);

    // ALU only
    alu_valid = 1; alu_id = 5; alu_data = 32'hDEAD_BEEF;
    tick();
    chk_wr("alu5", 1, 5, 32'hDEAD_BEEF);
    alu_id = 0; alu_data = 32'h1234;
    tick();
    chk_wr("alu0", 0, 0, 0);
    chk("alu0_id_hold", 32'(rf_write_id), 5);
    chk("alu0_data_hold", rf_write_data, 32'hDEAD_BEEF);
    idle();
    lat_valid = 1; lat_id = 0; lat_data = 32'h99;
    tick();
    chk("lat0_discard", 32'(fifo_count), 0);
    idle();
    tick();
    chk_wr("lat0_nowrite", 0, 0, 0);

    // Scoreboard
    reserve_en = 1; reserve_id = 7;
    tick();
    idle();
    chk("res7", pending, 32'h80);
    lat_valid = 1; lat_id = 7; lat_data = 32'h11;
    tick();
    idle();
    chk_wr("lat7_m1", 0, 0, 0);
    chk("lat7_m1_count", 32'(fifo_count), 1);
    chk("lat7_m1_pend", pending, 32'h80);
    tick();
    chk_wr("lat7_m2", 1, 7, 32'h11);
    chk("lat7_m2_pend", pending, 0);
    chk("lat7_m2_count", 32'(fifo_count), 0);
    reserve_en = 1; reserve_id = 7;
    tick();
    idle();
    lat_valid = 1; lat_id = 7; lat_data = 32'h22;
    tick();
    idle();
    reserve_en = 1; reserve_id = 7;
    tick();
    idle();
    chk_wr("setwin_wr", 1, 7, 32'h22);
    chk("setwin_pend", pending, 32'h80);
    reserve_en = 1; reserve_id = 0;
    tick();
    idle();
    chk("res0_pend", pending, 32'h80);

    // FIFO fill while ALU busy, then in-order drain
    alu_valid = 1; alu_id = 10; alu_data = 32'hA0;
    for (int i = 1; i <= 4; i++) begin
      lat_valid = 1; lat_id = 5'(i); lat_data = 32'h100 + 32'(i);
      tick();
      chk_wr("fill_alu", 1, 10, 32'hA0);
    end
    chk("full_count", 32'(fifo_count), 4);
    chk("full_ready", 32'(lat_ready), 0);
    chk("full_stall", 32'(alu_stall), 1);
    idle();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_wr("drain", 1, 5'(i), 32'h100 + 32'(i));
      chk("drain_count", 32'(fifo_count), 32'(4 - i));
    end
    tick();
    chk_wr("drain_done", 0, 0, 0);

    // Starvation relief
    alu_valid = 1; alu_id = 13; alu_data = 32'h1000;
    lat_valid = 1; lat_id = 12; lat_data = 32'h55;
    tick();
    lat_valid = 0;
    chk_wr("st_push", 1, 13, 32'h1000);
    chk("st_count", 32'(fifo_count), 1);
    for (int k = 1; k <= 3; k++) begin
      alu_data = 32'h1000 + 32'(k);
      chk("st_nostall", 32'(alu_stall), 0);
      tick();
      chk_wr("st_alu", 1, 13, 32'h1000 + 32'(k));
    end
    alu_data = 32'h1004;
    chk("st_stall", 32'(alu_stall), 1);
    tick();
    chk_wr("st_fifo", 1, 12, 32'h55);
    chk("st_count0", 32'(fifo_count), 0);
    chk("st_unstall", 32'(alu_stall), 0);
    tick();
    chk_wr("st_held", 1, 13, 32'h1004);
    idle();
    tick();

    // Reset mid-operation drops buffered entries
    alu_valid = 1; alu_id = 20; alu_data = 32'h0;
    lat_valid = 1; lat_id = 1; lat_data = 32'h201; reserve_en = 1; reserve_id = 1;
    tick();
    lat_id = 2; lat_data = 32'h202; reserve_id = 2;
    tick();
    lat_id = 7; lat_data = 32'h207; reserve_en = 0; reserve_id = 0;
    tick();
    idle();
    chk("mid_count", 32'(fifo_count), 3);
    chk("mid_pend", pending, 32'h86);
    reset_n = 0;
    tick();
    reset_n = 1;
    chk_wr("mid_rst", 0, 0, 0);
    chk("mid_rst_id", 32'(rf_write_id), 0);
    chk("mid_rst_pend", pending, 0);
    chk("mid_rst_count", 32'(fifo_count), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_wr("post_rst", 0, 0, 0);
      chk("post_rst_count", 32'(fifo_count), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

- Producer end of the register-file write port.
- Merges single-cycle ALU results and long-latency results (load/mul/div) into the one register-file write per cycle.
- Long-latency results are buffered in order.
- Keeps a pending-destination scoreboard that the issue stage uses to detect RAW hazards on outstanding long-latency ops.

## Interface

Parameters:
- FIFO_DEPTH, 4 — long-latency result buffer entries (power of two, ≥2).
- STARVE_LIMIT, 3 — consecutive cycles a non-empty FIFO may lose arbitration before ALU is stalled.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- alu_valid  in  1  ALU result present this cycle.
- alu_id  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_stall  out  1  ALU result not accepted; source holds alu_* stable.
- lat_valid  in  1  long-latency result offered.
- lat_ready  out  1  FIFO can accept.
- lat_id  in  5  long-latency destination.
- lat_data  in  32  long-latency result.
- reserve_en  in  1  issue stage dispatched a long-latency op.
- reserve_id  in  5  its destination register.
- rf_write_en  out  1  register-file write enable (registered).
- rf_write_id  out  5  register-file write index (registered).
- rf_write_data  out  32  register-file write data (registered).
- pending  out  32  bit i set = register i has an outstanding long-latency write.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation

- Enqueue: lat_valid && lat_ready enqueues {lat_id, lat_data}, except lat_id==0, which is accepted and discarded.
- lat_ready = reset_n && (fifo_count < FIFO_DEPTH). No dependence on same-cycle pop.
- Arbitration, once per cycle:
  - If alu_stall=0 and alu_valid and alu_id≠0: ALU selected.
  - Else if FIFO non-empty: head popped and selected.
  - Else: nothing selected.
- alu_valid with alu_id==0 is accepted without write and without affecting arbitration.
- Starvation counter starve_cnt (0..STARVE_LIMIT):
  - Increments when FIFO is non-empty and ALU wins.
  - Clears on any FIFO pop, or when the FIFO is empty.
- alu_stall = (starve_cnt == STARVE_LIMIT) && FIFO non-empty. Combinational from registered state.
- Selected entry is loaded into the rf_write_* registers at the next edge. With no selection, rf_write_en←0; rf_write_id and rf_write_data hold.
- Scoreboard, at each edge:
  - pending[reserve_id] set if reserve_en && reserve_id≠0.
  - pending[sel_id] cleared when a FIFO entry is committed, in the same edge that raises rf_write_en.
  - Same register reserved and cleared in one cycle: set wins, because a new op was dispatched.
  - ALU writes never touch pending.
- pending[0] is constant 0.
- FIFO is strictly in order. Pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop at full or empty is legal:
  - Empty: push lands, no pop occurs.
  - Full: lat_ready=0, so no push.

## Timing

- ALU accepted at cycle N → rf_write_en=1 at N+1.
- Long-latency enqueued at N → earliest rf write at N+2 (no FIFO bypass).
- pending bit clears in the same cycle rf_write_en shows that id. The register file's write-through bypass makes that cycle's read correct.
- Worst-case FIFO wait under continuous ALU traffic: STARVE_LIMIT+1 cycles.
- Reset, asserted any time, takes effect at the next edge:
  - FIFO emptied; fifo_count=0.
  - starve_cnt=0, pending=0.
  - rf_write_en=0, rf_write_id=0, rf_write_data=0.
  - alu_stall=0.
  - lat_ready=0 while reset_n is low.
- In-flight entries are dropped without a write.

## Structure

- Package common gains FIFO_DEPTH_WB and typedef wb_entry_t {logic [4:0] id; logic [31:0] data;}.
- REGISTER_FILE_SIZE is reused for the pending width.
- Sub-module wb_fifo:
  - Parameterized synchronous FIFO of wb_entry_t.
  - Ports: push, pop, head, count, full, empty.
- Arbitration, starvation counter, scoreboard and output registers live in the top level.

## Test plan

- Reset: hold reset_n=0 with all inputs active → rf_write_en=0, pending=0, fifo_count=0, lat_ready=0. After release, lat_ready=1.
- ALU only: alu_valid, id=5, data=0xDEADBEEF at N → rf_write_en=1, id=5, data=0xDEADBEEF at N+1. With id=0 → no write.
- Scoreboard: reserve id=7 at N → pending[7]=1 from N+1. Then lat id=7, data=0x11 at M (ALU idle) → write at M+2, pending[7]=0 in that same cycle. Reserving and clearing 7 in one cycle → pending[7] stays 1.
- FIFO full/order: push 4 entries (ids 1–4) while ALU is busy → lat_ready=0 and fifo_count=4. They drain in order 1,2,3,4 once ALU idles.
- Starvation: FIFO holds 1 entry and ALU is valid every cycle, STARVE_LIMIT=3 → ALU wins 3 cycles, then alu_stall=1 and the FIFO entry is written. alu_stall drops and the held ALU result is written next.
- Reset mid-operation: FIFO holds 3 entries, pending=0x0000_0086, then reset_n=0 for one cycle → no writes of the dropped entries, pending=0, fifo_count=0.
